// File: rtl/keypad_scan_ctrl.sv
// Scan controller for a 3x4 telephone keypad. It drives one row at a time,
// synchronizes the columns, debounces presses and releases, and hands each key
// to the consumer through a valid/ack register with a sticky overrun flag.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_CYCLES    = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [2:0] col,
  input  logic       key_ack,
  output logic [3:0] row_sel,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       overrun
);
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned NKEYS   = 12;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         col_m_q, col_s_q;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         row_q, row_d;
  logic [3:0]         row_sel_q, row_sel_d;
  logic [8:0]         acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         cand_q, cand_d;
  logic [3:0]         code_q, code_d;
  logic               valid_q, valid_d;
  logic               down_q, down_d;
  logic               ovr_q, ovr_d;

  logic               scan_done_c, accept_c;
  logic [NKEYS-1:0]   bits_c;
  logic [3:0]         ones_c;
  logic [3:0]         single_code_c;
  logic               empty_c, single_c;

  // Bit index is row*3 + column; rows d..g map to indices 0..3.
  function automatic logic [3:0] key_of(input int unsigned idx);
    case (idx)
      9:       key_of = 4'd10;
      10:      key_of = 4'd0;
      11:      key_of = 4'd11;
      default: key_of = 4'(idx + 1);
    endcase
  endfunction

  // Row g is still in the synchronizer output when the scan is evaluated.
  always_comb begin
    bits_c        = {col_s_q, acc_q};
    ones_c        = '0;
    single_code_c = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (bits_c[i]) begin
        ones_c        = ones_c + 4'd1;
        single_code_c = key_of(i);
      end
    end
    empty_c  = (ones_c == 4'd0);
    single_c = (ones_c == 4'd1);
  end

  always_comb begin
    dwell_d     = dwell_q;
    row_d       = row_q;
    row_sel_d   = row_sel_q;
    acc_d       = acc_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    code_d      = code_q;
    valid_d     = valid_q;
    down_d      = down_q;
    ovr_d       = ovr_q;
    scan_done_c = 1'b0;
    accept_c    = 1'b0;

    // A zero row drive marks a restart: the next cycle is row d, dwell 0.
    if (!scan_en) begin
      dwell_d   = '0;
      row_d     = '0;
      row_sel_d = 4'b0000;
      acc_d     = '0;
    end else if (row_sel_q == 4'b0000) begin
      row_sel_d = 4'b0001;
    end else if (dwell_q == DWELL_W'(SCAN_CYCLES - 1)) begin
      dwell_d   = '0;
      row_d     = row_q + 2'd1;
      row_sel_d = {row_sel_q[2:0], row_sel_q[3]};
      unique case (row_q)
        2'd0:    acc_d[2:0] = col_s_q;
        2'd1:    acc_d[5:3] = col_s_q;
        2'd2:    acc_d[8:6] = col_s_q;
        default: begin
          scan_done_c = 1'b1;
          acc_d       = '0;
        end
      endcase
    end else begin
      dwell_d = dwell_q + DWELL_W'(1);
    end

    if (valid_q && key_ack) valid_d = 1'b0;

    if (scan_done_c) begin
      unique case (state_q)
        IDLE: begin
          if (single_c) begin
            cand_d = single_code_c;
            cnt_d  = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) accept_c = 1'b1;
            else                     state_d  = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (single_c && (single_code_c == cand_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(DEBOUNCE_SCANS)) accept_c = 1'b1;
          end else if (single_c) begin
            cand_d = single_code_c;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (empty_c) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d = IDLE;
              down_d  = 1'b0;
            end else begin
              state_d = RELEASE;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        RELEASE: begin
          if (empty_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(DEBOUNCE_SCANS)) begin
              state_d = IDLE;
              down_d  = 1'b0;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // An ack on the accept edge frees the register for the new key.
    if (accept_c) begin
      state_d = HELD;
      down_d  = 1'b1;
      if (!valid_q || key_ack) begin
        code_d  = single_code_c;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_m_q   <= '0;
      col_s_q   <= '0;
      dwell_q   <= '0;
      row_q     <= '0;
      row_sel_q <= 4'b0001;
      acc_q     <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      cand_q    <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      down_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      col_m_q   <= col;
      col_s_q   <= col_m_q;
      dwell_q   <= dwell_d;
      row_q     <= row_d;
      row_sel_q <= row_sel_d;
      acc_q     <= acc_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      down_q    <= down_d;
      ovr_q     <= ovr_d;
    end
  end

  assign row_sel   = row_sel_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a physical keypad model drives the
// columns, and a scan-level reference model predicts the handshake outputs.
module tb_keypad_scan_ctrl;
  localparam int SC  = 4;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_en;
  logic [2:0] col;
  logic       key_ack;
  logic [3:0] row_sel;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       overrun;

  logic [11:0] pressed;
  int          checks = 0;
  int          errors = 0;

  bit          m_valid, m_down, m_ovr;
  logic [3:0]  m_code, run_key;
  int          run_len, rel_len;

  keypad_scan_ctrl #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DEB)) dut (
    .clk      (clk),
    .reset    (reset),
    .scan_en  (scan_en),
    .col      (col),
    .key_ack  (key_ack),
    .row_sel  (row_sel),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Keypad switch matrix: a closed key connects its driven row to its column.
  always_comb begin
    col = (row_sel[0] ? pressed[2:0]  : 3'b000) |
          (row_sel[1] ? pressed[5:3]  : 3'b000) |
          (row_sel[2] ? pressed[8:6]  : 3'b000) |
          (row_sel[3] ? pressed[11:9] : 3'b000);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [11:0] key_mask(input int code);
    int idx;
    case (code)
      10:      idx = 9;
      0:       idx = 10;
      11:      idx = 11;
      default: idx = code - 1;
    endcase
    return 12'(1) << idx;
  endfunction

  function automatic logic [3:0] code_of(input logic [11:0] keys);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 12; i++)
      if (keys[i]) c = (i == 9) ? 4'd10 : (i == 10) ? 4'd0 : (i == 11) ? 4'd11 : 4'(i + 1);
    return c;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_down = 0; m_ovr = 0; m_code = 4'd0;
    run_key = 4'd0; run_len = 0; rel_len = 0;
  endtask

  // One full scan seen by the reference: run-length press/release tracking.
  task automatic model_step(input logic [11:0] keys, input bit ack);
    int         n;
    bit         acc, pre;
    logic [3:0] k;
    n   = $countones(keys);
    k   = code_of(keys);
    acc = 0;
    pre = m_valid;
    if (!m_down) begin
      if (n == 1) begin
        if (run_len > 0 && k == run_key) run_len++;
        else begin run_key = k; run_len = 1; end
        if (run_len == DEB) begin acc = 1; run_len = 0; end
      end else run_len = 0;
    end else begin
      if (n == 0) begin
        rel_len++;
        if (rel_len == DEB) begin m_down = 0; rel_len = 0; end
      end else rel_len = 0;
    end
    if (ack && pre) m_valid = 0;
    if (acc) begin
      m_down = 1;
      if (!pre || ack) begin m_code = k; m_valid = 1; end
      else m_ovr = 1;
    end
  endtask

  // Entered at the negedge of the first row-d cycle; leaves at the next one.
  task automatic run_scan(input logic [11:0] keys, input bit ack);
    logic [3:0] exp_rs;
    pressed = keys;
    for (int i = 0; i < 4 * SC; i++) begin
      if (i % SC == 0) begin
        exp_rs = 4'b0001 << (i / SC);
        checks++;
        if (row_sel !== exp_rs) begin
          errors++;
          $display("FAIL row_rotation cycle %0d: got %b expected %b", i, row_sel, exp_rs);
        end
      end
      if (i == 4 * SC - 1) key_ack = ack;
      @(posedge clk);
      @(negedge clk);
    end
    key_ack = 1'b0;
    model_step(keys, ack);
    checks++;
    if (key_valid !== m_valid) begin errors++; $display("FAIL scan_valid: got %b expected %b", key_valid, m_valid); end
    checks++;
    if (key_code !== m_code) begin errors++; $display("FAIL scan_code: got %0d expected %0d", key_code, m_code); end
    checks++;
    if (key_down !== m_down) begin errors++; $display("FAIL scan_down: got %b expected %b", key_down, m_down); end
    checks++;
    if (overrun !== m_ovr) begin errors++; $display("FAIL scan_overrun: got %b expected %b", overrun, m_ovr); end
  endtask

  task automatic ack_and_release();
    run_scan(12'd0, 1'b1);
    repeat (DEB) run_scan(12'd0, 1'b0);
  endtask

  task automatic test_reset();
    checks++;
    if (row_sel !== 4'b0001) begin errors++; $display("FAIL reset_row_sel: got %b expected 0001", row_sel); end
    checks++;
    if (key_code !== 4'd0) begin errors++; $display("FAIL reset_key_code: got %0d expected 0", key_code); end
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
    checks++;
    if (key_down !== 1'b0) begin errors++; $display("FAIL reset_key_down: got %b expected 0", key_down); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_single_press();
    run_scan(key_mask(5), 1'b0);
    run_scan(key_mask(5), 1'b0);
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL press_early_valid: got %b expected 0", key_valid); end
    run_scan(key_mask(5), 1'b0);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'd5 || key_down !== 1'b1) begin
      errors++;
      $display("FAIL press_key5: got valid %b code %0d down %b expected 1 5 1", key_valid, key_code, key_down);
    end
    run_scan(key_mask(5), 1'b1);
    checks++;
    if (key_valid !== 1'b0 || key_down !== 1'b1) begin
      errors++;
      $display("FAIL press_ack: got valid %b down %b expected 0 1", key_valid, key_down);
    end
    repeat (DEB) run_scan(12'd0, 1'b0);
    checks++;
    if (key_down !== 1'b0) begin errors++; $display("FAIL press_release: got down %b expected 0", key_down); end
  endtask

  task automatic test_bounce();
    run_scan(key_mask(5), 1'b0);
    run_scan(key_mask(5), 1'b0);
    run_scan(12'd0, 1'b0);
    run_scan(key_mask(5), 1'b0);
    run_scan(key_mask(5), 1'b0);
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_discard: got valid %b expected 0", key_valid); end
    run_scan(key_mask(5), 1'b0);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'd5) begin
      errors++;
      $display("FAIL bounce_accept: got valid %b code %0d expected 1 5", key_valid, key_code);
    end
    ack_and_release();
  endtask

  task automatic test_multi();
    repeat (4) run_scan(key_mask(0) | key_mask(8), 1'b0);
    checks++;
    if (key_valid !== 1'b0 || key_down !== 1'b0) begin
      errors++;
      $display("FAIL multi_rejected: got valid %b down %b expected 0 0", key_valid, key_down);
    end
    run_scan(12'd0, 1'b0);
  endtask

  task automatic test_same_edge_ack();
    repeat (DEB) run_scan(key_mask(3), 1'b0);
    repeat (DEB) run_scan(12'd0, 1'b0);
    run_scan(key_mask(11), 1'b0);
    run_scan(key_mask(11), 1'b0);
    run_scan(key_mask(11), 1'b1);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'd11 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_ack: got valid %b code %0d ovr %b expected 1 11 0", key_valid, key_code, overrun);
    end
    ack_and_release();
  endtask

  task automatic test_overrun();
    repeat (DEB) run_scan(key_mask(1), 1'b0);
    repeat (DEB) run_scan(12'd0, 1'b0);
    repeat (DEB) run_scan(key_mask(9), 1'b0);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'd1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun: got valid %b code %0d ovr %b expected 1 1 1", key_valid, key_code, overrun);
    end
    ack_and_release();
  endtask

  task automatic test_scan_en();
    bit bad;
    repeat (DEB) run_scan(key_mask(7), 1'b0);
    run_scan(key_mask(7), 1'b1);
    repeat (2 * SC + 1) begin @(posedge clk); @(negedge clk); end
    checks++;
    if (row_sel !== 4'b0100) begin errors++; $display("FAIL en_mid_row_f: got %b expected 0100", row_sel); end
    scan_en = 1'b0;
    @(posedge clk); @(negedge clk);
    bad = 0;
    repeat (20) begin
      if (row_sel !== 4'b0000) bad = 1;
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (bad) begin errors++; $display("FAIL en_row_off: got row_sel %b expected 0000", row_sel); end
    checks++;
    if (key_down !== 1'b1 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_hold_state: got down %b valid %b expected 1 0", key_down, key_valid);
    end
    scan_en = 1'b1;
    @(posedge clk); @(negedge clk);
    run_scan(key_mask(7), 1'b0);
    repeat (DEB) run_scan(12'd0, 1'b0);
  endtask

  task automatic test_random();
    int          s, mode, len, a, b;
    logic [11:0] keys;
    s = 0;
    while (s < 40) begin
      mode = $urandom_range(0, 9);
      len  = $urandom_range(1, 5);
      if (mode < 3) keys = 12'd0;
      else if (mode < 8) keys = 12'(1) << $urandom_range(0, 11);
      else begin
        a    = $urandom_range(0, 11);
        b    = (a + $urandom_range(1, 11)) % 12;
        keys = (12'(1) << a) | (12'(1) << b);
      end
      for (int j = 0; j < len && s < 40; j++) begin
        run_scan(keys, $urandom_range(0, 3) == 0);
        s++;
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    pressed = key_mask(4);
    repeat (6) begin @(posedge clk); @(negedge clk); end
    #2 reset = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    pressed = 12'd0;
    key_ack = 1'b0;
    reset   = 1'b1;
    model_reset();
    repeat (DEB) run_scan(key_mask(2), 1'b0);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'd2 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_press: got valid %b code %0d ovr %b expected 1 2 0", key_valid, key_code, overrun);
    end
  endtask

  initial begin
    reset   = 1'b0;
    scan_en = 1'b1;
    key_ack = 1'b0;
    pressed = 12'd0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    test_single_press();
    test_bounce();
    test_multi();
    test_same_edge_ack();
    test_overrun();
    test_scan_en();
    test_random();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
